// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: prescaled WIDTH-bit up-counter with terminal-count
// tick, one-shot (stops in DONE) or periodic (reloads to 0) operation.
module interval_timer_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      terminal,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tick,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [WIDTH-1:0]      count_n;
  logic [PRESCALE_W-1:0] pre_cnt, pre_n;
  logic                  tick_n;
  logic [WIDTH-1:0]      terminal_q, terminal_n;
  logic [PRESCALE_W-1:0] prescale_q, prescale_n;
  logic                  mode_q, mode_n;
  logic                  advance;

  assign advance   = (state == RUN) && (pre_cnt == prescale_q);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

  // stop outranks start, and both outrank the counting path, so a stop on a
  // terminal advance suppresses the tick and freezes the pre-advance count.
  always_comb begin
    state_n    = state;
    count_n    = count;
    pre_n      = pre_cnt;
    tick_n     = 1'b0;
    terminal_n = terminal_q;
    prescale_n = prescale_q;
    mode_n     = mode_q;
    if (stop) begin
      if (state == RUN) begin
        state_n = IDLE;
        pre_n   = '0;
      end
    end else if (start) begin
      terminal_n = terminal;
      prescale_n = prescale;
      mode_n     = mode;
      count_n    = '0;
      pre_n      = '0;
      state_n    = RUN;
    end else if (state == RUN) begin
      if (advance) begin
        pre_n = '0;
        if (count == terminal_q) begin
          tick_n = 1'b1;
          if (mode_q) count_n = '0;
          else        state_n = DONE;
        end else begin
          count_n = count + WIDTH'(1);
        end
      end else begin
        pre_n = pre_cnt + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      pre_cnt    <= '0;
      tick       <= 1'b0;
      terminal_q <= '0;
      prescale_q <= '0;
      mode_q     <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      pre_cnt    <= pre_n;
      tick       <= tick_n;
      terminal_q <= terminal_n;
      prescale_q <= prescale_n;
      mode_q     <= mode_n;
    end
  end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl: per-cycle vector table plus sequences
// for asynchronous reset mid-run and a full-range periodic count.
module tb_interval_timer_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       mode;
  logic [3:0] terminal;
  logic [3:0] prescale;
  logic [3:0] count;
  logic       tick;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  int total;
  int bad;

  typedef struct {
    logic       st;
    logic       sp;
    logic       md;
    logic [3:0] term;
    logic [3:0] pre;
    logic [3:0] e_count;
    logic       e_tick;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];

  interval_timer_ctrl #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .terminal  (terminal),
    .prescale  (prescale),
    .count     (count),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic md, input int term,
                     input int pre, input int e_count, input logic e_tick,
                     input logic e_busy, input logic e_done);
    vec_t v;
    v.st = st; v.sp = sp; v.md = md;
    v.term = 4'(term); v.pre = 4'(pre);
    v.e_count = 4'(e_count); v.e_tick = e_tick; v.e_busy = e_busy; v.e_done = e_done;
    vecs.push_back(v);
  endtask

  // driver: apply inputs after the falling edge, sample 1 time unit after the rising edge
  task automatic drive(input logic st, input logic sp, input logic md,
                       input logic [3:0] term, input logic [3:0] pre);
    @(negedge clk);
    start = st; stop = sp; mode = md; terminal = term; prescale = pre;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input int e_count, input logic e_tick,
                               input logic e_busy, input logic e_done);
    check({tag, ".count"}, int'(count), e_count);
    check({tag, ".tick"},  int'(tick),  int'(e_tick));
    check({tag, ".busy"},  int'(busy),  int'(e_busy));
    check({tag, ".done"},  int'(done),  int'(e_done));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    start = 1'b0; stop = 1'b0; mode = 1'b0; terminal = '0; prescale = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // one-shot, terminal=3, prescale=0
    add(1, 0, 0, 3, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 2, 0, 1, 0);
    add(0, 0, 0, 0, 0, 3, 0, 1, 0);
    add(0, 0, 0, 0, 0, 3, 1, 0, 1);
    add(0, 0, 0, 0, 0, 3, 0, 0, 1);
    add(0, 0, 0, 0, 0, 3, 0, 0, 1);
    // periodic, terminal=2, prescale=1
    add(1, 0, 1, 2, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 2, 0, 1, 0);
    add(0, 0, 0, 0, 0, 2, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 2, 0, 1, 0);
    // restart at count=2 with new one-shot config terminal=1
    add(1, 0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 1);
    // start from DONE, then stop at count=2
    add(1, 0, 1, 5, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 2, 0, 1, 0);
    add(0, 1, 0, 0, 0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 2, 0, 0, 0);
    // stop coinciding with a terminal advance: no tick, count held
    add(1, 0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0, 0);
    // start+stop together in RUN and in IDLE
    add(1, 0, 1, 5, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(1, 1, 1, 5, 0, 1, 0, 0, 0);
    add(1, 1, 1, 5, 0, 1, 0, 0, 0);
    // terminal=0, prescale=3, periodic: count stays 0, tick every 4 clocks
    add(1, 0, 1, 0, 3, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0);
    // config changes mid-run are ignored: one-shot terminal=4 still completes
    add(1, 0, 0, 4, 0, 0, 0, 1, 0);
    add(0, 0, 1, 1, 3, 1, 0, 1, 0);
    add(0, 0, 1, 1, 3, 2, 0, 1, 0);
    add(0, 0, 1, 1, 3, 3, 0, 1, 0);
    add(0, 0, 1, 1, 3, 4, 0, 1, 0);
    add(0, 0, 1, 1, 3, 4, 1, 0, 1);
    add(0, 0, 1, 1, 3, 4, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].md, vecs[i].term, vecs[i].pre);
      check_outputs($sformatf("vec%0d", i), int'(vecs[i].e_count), vecs[i].e_tick,
                    vecs[i].e_busy, vecs[i].e_done);
    end

    // asynchronous reset while running at count=3
    drive(1, 0, 1, 4'd5, 4'd0);
    drive(0, 0, 0, 4'd0, 4'd0);
    drive(0, 0, 0, 4'd0, 4'd0);
    drive(0, 0, 0, 4'd0, 4'd0);
    check("rst_pre.count", int'(count), 3);
    #2;
    reset = 1'b1;
    #1;
    check_outputs("rst_async", 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 4'd0, 4'd0);
      check_outputs($sformatf("rst_after%0d", k), 0, 1'b0, 1'b0, 1'b0);
    end

    // full-range periodic: count walks 0..15 then reloads via terminal tick
    drive(1, 0, 1, 4'd15, 4'd0);
    check_outputs("wide_start", 0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 20; k++) exp_q.push_back(4'(k % 16));
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] e;
      drive(0, 0, 0, 4'd0, 4'd0);
      e = exp_q.pop_front();
      check($sformatf("wide%0d.count", k), int'(count), int'(e));
      check($sformatf("wide%0d.tick", k), int'(tick), (k == 16) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
